cnt_rr_arbiter: RTL

CNT_RR_ARBITER -- requirements
Module: cnt_rr_arbiter

---
 rtl/cnt_rr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cnt_rr_arbiter.sv
// Round-robin arbiter for a shared cycle counter. A grant lasts up to hold_len
// cycles (0 counts as 1) and ends early on release or when the grantee drops
// its request. There is always an idle cycle between grants.
module cnt_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [LEN_W-1:0] hold_len_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       gnt_id_o,
  output logic             busy_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic             phase_o
);

  localparam int unsigned ID_W = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             phase_q, phase_d;

  logic             win_found_c;
  logic [ID_W-1:0]  win_id_c;
  logic [ID_W-1:0]  cand_c;
  logic [LEN_W-1:0] len_m1_c;
  logic             term_c;

  // Round-robin search starting just after the most recent grantee, with wrap
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = last_id_q;
    cand_c      = last_id_q;
    for (int k = 1; k <= 4; k++) begin
      cand_c = ID_W'(last_id_q + ID_W'(k));
      if (!win_found_c && req_i[cand_c]) begin
        win_found_c = 1'b1;
        win_id_c    = cand_c;
      end
    end
  end

  // Grant termination: length reached, early release, or grantee request dropped
  always_comb begin
    len_m1_c = LEN_W'(len_q - LEN_W'(1));
    term_c   = (cnt_q == len_m1_c) | release_i | ~req_i[last_id_q];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found_c) state_d = S_GRANT;
      S_GRANT: if (term_c)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gnt_d     = '0;
    busy_d    = 1'b0;
    phase_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (win_found_c) begin
        last_id_d = win_id_c;
        cnt_d     = '0;
        len_d     = (hold_len_i == '0) ? LEN_W'(1) : hold_len_i;
      end
    end else if (!term_c) begin
      // cnt never passes len_q-1, so this increment cannot wrap
      cnt_d = LEN_W'(cnt_q + LEN_W'(1));
    end

    if (state_d == S_GRANT) begin
      gnt_d   = N_REQ'(1) << last_id_d;
      busy_d  = 1'b1;
      phase_d = cnt_d[0];
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= ID_W'(3);
      cnt_q     <= '0;
      len_q     <= LEN_W'(1);
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      phase_q   <= phase_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = last_id_q;
  assign busy_o   = busy_q;
  assign cnt_o    = cnt_q;
  assign phase_o  = phase_q;

endmodule
